// File: rtl/hpdmc_pkg.sv
// Shared types and elaboration helpers for the HPDMC DDR write datapath.
package hpdmc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_PRE  = 3'd2,
    ST_DATA = 3'd3,
    ST_POST = 3'd4
  } wr_state_e;

  // Wide enough for WL-1 (max 6) and BURST_LEN-1 (max 15).
  localparam int CNT_W = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  function automatic int dm_width(input int dq_width);
    return dq_width / 8;
  endfunction

endpackage

// File: rtl/hpdmc_wrfifo.sv
// Synchronous write-data FIFO: no fall-through, push refused while full.
module hpdmc_wrfifo
  import hpdmc_pkg::*;
#(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int CW = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/hpdmc_ddr_wrpath.sv
// DDR write datapath: buffers burst data and sequences DQ/DM/DQS ODDR inputs
// through write latency, preamble, data and postamble.
module hpdmc_ddr_wrpath
  import hpdmc_pkg::*;
#(
  parameter int DQ_WIDTH   = 16,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int WL         = 1
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*DQ_WIDTH-1:0]       in_data,
  input  logic [2*(DQ_WIDTH/8)-1:0]   in_mask,
  input  logic                        wr_start,
  output logic                        busy,
  output logic                        overlap,
  output logic                        underrun,
  output logic [DQ_WIDTH-1:0]         dq_d0,
  output logic [DQ_WIDTH-1:0]         dq_d1,
  output logic [DQ_WIDTH/8-1:0]       dm_d0,
  output logic [DQ_WIDTH/8-1:0]       dm_d1,
  output logic                        dq_oe,
  output logic                        dqs_d0,
  output logic                        dqs_d1,
  output logic                        dqs_oe
);

  localparam int DM_W   = dm_width(DQ_WIDTH);
  localparam int WORD_W = 2 * DQ_WIDTH + 2 * DM_W;
  localparam logic [CNT_W-1:0] WL_LAST = CNT_W'((WL > 0) ? WL - 1 : 0);
  localparam logic [CNT_W-1:0] BL_LAST = CNT_W'(BURST_LEN - 1);

  wr_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  overlap_q, overlap_d;
  logic                  underrun_q, underrun_d;
  logic [DQ_WIDTH-1:0]   dq_d0_q, dq_d0_d, dq_d1_q, dq_d1_d;
  logic [DM_W-1:0]       dm_d0_q, dm_d0_d, dm_d1_q, dm_d1_d;
  logic                  dq_oe_q, dq_oe_d;
  logic                  dqs_d0_q, dqs_d0_d;
  logic                  dqs_d1_q, dqs_d1_d;
  logic                  dqs_oe_q, dqs_oe_d;

  logic                  data_phase;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [WORD_W-1:0]     fifo_rd;

  hpdmc_wrfifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .push    (in_valid),
    .pop     (fifo_pop),
    .wr_data ({in_mask, in_data}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign in_ready = !fifo_full;

  // Outputs are decoded from the next state so they appear in the same
  // cycle the FSM enters that state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_start) begin
          if (WL > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WL_LAST;
          end else begin
            state_d = ST_PRE;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_PRE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_PRE: begin
        state_d = ST_DATA;
        cnt_d   = BL_LAST;
      end
      ST_DATA: begin
        if (cnt_q == '0) state_d = ST_POST;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_POST: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    data_phase = (state_d == ST_DATA);
    fifo_pop   = data_phase && !fifo_empty;
    overlap_d  = wr_start && (state_q != ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    dq_oe_d    = data_phase;
    dqs_d0_d   = data_phase;
    dqs_d1_d   = 1'b0;
    dqs_oe_d   = (state_d == ST_PRE) || (state_d == ST_DATA) || (state_d == ST_POST);
    underrun_d = data_phase && fifo_empty;

    // An empty FIFO during DATA drives zeros fully masked.
    dq_d0_d = '0;
    dq_d1_d = '0;
    dm_d0_d = '1;
    dm_d1_d = '1;
    if (fifo_pop) begin
      {dm_d1_d, dm_d0_d, dq_d1_d, dq_d0_d} = fifo_rd;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      overlap_q  <= 1'b0;
      underrun_q <= 1'b0;
      dq_d0_q    <= '0;
      dq_d1_q    <= '0;
      dm_d0_q    <= '1;
      dm_d1_q    <= '1;
      dq_oe_q    <= 1'b0;
      dqs_d0_q   <= 1'b0;
      dqs_d1_q   <= 1'b0;
      dqs_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      overlap_q  <= overlap_d;
      underrun_q <= underrun_d;
      dq_d0_q    <= dq_d0_d;
      dq_d1_q    <= dq_d1_d;
      dm_d0_q    <= dm_d0_d;
      dm_d1_q    <= dm_d1_d;
      dq_oe_q    <= dq_oe_d;
      dqs_d0_q   <= dqs_d0_d;
      dqs_d1_q   <= dqs_d1_d;
      dqs_oe_q   <= dqs_oe_d;
    end
  end

  assign busy     = busy_q;
  assign overlap  = overlap_q;
  assign underrun = underrun_q;
  assign dq_d0    = dq_d0_q;
  assign dq_d1    = dq_d1_q;
  assign dm_d0    = dm_d0_q;
  assign dm_d1    = dm_d1_q;
  assign dq_oe    = dq_oe_q;
  assign dqs_d0   = dqs_d0_q;
  assign dqs_d1   = dqs_d1_q;
  assign dqs_oe   = dqs_oe_q;

endmodule
